mm_tile_loader: RTL

//  Upstream feeder for the 16x16 matrix-vector multiply array. Collects one operand vector plus M

---
 rtl/mm_tile_loader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mm_tile_loader.sv
// Tile loader for the 16x16 matrix-vector array: gathers one vector beat plus M slice beats,
// pulses mm_valid, then holds the operands until mm_done. Optional counters: MM_TILE_LOADER_CNT_EN.
module mm_tile_loader #(
   parameter int M  = 16,
   parameter int N  = 16,
   parameter int DW = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DW*N-1:0]     in_data,
   input  logic                in_valid,
   input  logic                in_last,
   output logic                in_ready,
   output logic [DW*N*M-1:0]   mat_out,
   output logic [DW*N-1:0]     vec_out,
   output logic                mm_valid,
   input  logic                mm_done,
   output logic                busy,
   output logic                err
`ifdef MM_TILE_LOADER_CNT_EN
   ,
   output logic [15:0]         tile_cnt,
   output logic [31:0]         stall_cnt
`endif
);

   localparam int SW    = DW * N;
   localparam int CNT_W = $clog2(M + 1);

   typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_WAIT} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   beat_cnt_q;
   logic [SW*M-1:0]    mat_q;
   logic [SW-1:0]      vec_q;
   logic               mm_valid_q;
   logic               busy_q;
   logic               err_q;
   logic               xfer_s;

   assign in_ready = (state_q == S_LOAD) && !rst;
   assign xfer_s   = in_valid && in_ready;

   // Tile sequencing, operand capture and framing checks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_LOAD;
         beat_cnt_q <= '0;
         mat_q      <= '0;
         vec_q      <= '0;
         mm_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         mm_valid_q <= 1'b0;
         case (state_q)
            S_LOAD: begin
               if (xfer_s) begin
                  if (beat_cnt_q == '0) begin
                     vec_q <= in_data;
                  end
                  for (int k = 0; k < M; k++) begin
                     if (beat_cnt_q == CNT_W'(k + 1)) begin
                        mat_q[k*SW +: SW] <= in_data;
                     end
                  end
                  // A bad frame drops the partial tile; data already captured is left in place
                  if (beat_cnt_q == CNT_W'(M)) begin
                     beat_cnt_q <= '0;
                     if (in_last) begin
                        state_q    <= S_ISSUE;
                        mm_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                     end else begin
                        err_q <= 1'b1;
                     end
                  end else if (in_last) begin
                     beat_cnt_q <= '0;
                     err_q      <= 1'b1;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                  end
               end
            end
            S_ISSUE: begin
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (mm_done) begin
                  state_q <= S_LOAD;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_LOAD;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign mat_out  = mat_q;
   assign vec_out  = vec_q;
   assign mm_valid = mm_valid_q;
   assign busy     = busy_q;
   assign err      = err_q;

`ifdef MM_TILE_LOADER_CNT_EN
   logic [15:0] tile_cnt_q;
   logic [31:0] stall_cnt_q;

   // Issued-tile count wraps; stall count saturates
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tile_cnt_q  <= 16'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         if (state_q == S_ISSUE) begin
            tile_cnt_q <= tile_cnt_q + 16'd1;
         end
         if ((state_q == S_WAIT) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign tile_cnt  = tile_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule
